// File: rtl/led_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : led_seq_pkg
// Brief    : State encodings, mode constants and mode resolution for led_seq_gen.
//            Honours macro LED_SEQ_BOUNCE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_BACK  = 3'd4
  } led_state_t;

  localparam logic [1:0] MODE_FILL_LSB = 2'd0;
  localparam logic [1:0] MODE_FILL_MSB = 2'd1;
  localparam logic [1:0] MODE_DOT      = 2'd2;
  localparam logic [1:0] MODE_BOUNCE   = 2'd3;

  // Without bounce support, mode 3 is folded onto the LSB fill-drain pattern.
  function automatic logic [1:0] resolve_mode(input logic [1:0] m);
`ifdef LED_SEQ_BOUNCE_EN
    return m;
`else
    return (m == MODE_BOUNCE) ? MODE_FILL_LSB : m;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_seq_prescaler.sv
//------------------------------------------------------------------------------
// Module   : led_seq_prescaler
// Brief    : Enable-gated step prescaler; ticks when count >= div, then clears.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module led_seq_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;

  // Compared against the live div so a lowered div takes effect at once.
  assign tick = enable && (r_count >= div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      if (tick) r_count <= '0;
      else      r_count <= r_count + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_seq_gen.sv
//------------------------------------------------------------------------------
// Module   : led_seq_gen
// Brief    : LED pattern sequencer (fill-drain, running dot, bounce) stepped by
//            a prescaler tick. Bounce built only with macro LED_SEQ_BOUNCE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module led_seq_gen
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             cycle_done
);

  localparam logic [WIDTH-1:0] c_lsb = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_msb = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_tick;
  led_state_t       r_state, w_state_n;
  logic [1:0]       r_mode, w_mode_n;
  logic [WIDTH-1:0] r_q, w_q_n;
  logic             r_step, w_step_n;
  logic             r_done, w_done_n;

  led_seq_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .div    (div),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_FILL_LSB;
      r_q     <= '0;
      r_step  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_mode  <= w_mode_n;
      r_q     <= w_q_n;
      r_step  <= w_step_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_mode_n  = r_mode;
    w_q_n     = r_q;
    w_step_n  = 1'b0;
    w_done_n  = 1'b0;
    if (w_tick) begin
      w_step_n = 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_mode_n = resolve_mode(mode);
          case (w_mode_n)
            MODE_FILL_LSB: begin w_state_n = ST_FILL; w_q_n = c_lsb; end
            MODE_FILL_MSB: begin w_state_n = ST_FILL; w_q_n = c_msb; end
            default:       begin w_state_n = ST_RUN;  w_q_n = c_lsb; end
          endcase
        end
        ST_FILL: begin
          if (&r_q) begin
            w_state_n = ST_DRAIN;
            w_q_n     = (r_mode == MODE_FILL_MSB) ? (r_q >> 1) : (r_q << 1);
          end else begin
            w_q_n = (r_mode == MODE_FILL_MSB) ? ((r_q >> 1) | c_msb) : ((r_q << 1) | c_lsb);
          end
        end
        ST_DRAIN: begin
          w_q_n = (r_mode == MODE_FILL_MSB) ? (r_q >> 1) : (r_q << 1);
          if (w_q_n == '0) begin
            w_state_n = ST_IDLE;
            w_done_n  = 1'b1;
          end
        end
        ST_RUN: begin
          if (r_q[WIDTH-1]) begin
            w_state_n = ST_IDLE;
            w_q_n     = '0;
            w_done_n  = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
            // A 2-LED bounce has no interior LED, so it ends at the MSB.
            if (r_mode == MODE_BOUNCE && WIDTH > 2) begin
              w_state_n = ST_BACK;
              w_q_n     = c_msb >> 1;
              w_done_n  = 1'b0;
            end
`endif
          end else begin
            w_q_n = r_q << 1;
          end
        end
`ifdef LED_SEQ_BOUNCE_EN
        ST_BACK: begin
          if (r_q[1]) begin
            w_state_n = ST_IDLE;
            w_q_n     = '0;
            w_done_n  = 1'b1;
          end else begin
            w_q_n = r_q >> 1;
          end
        end
`endif
        default: begin
          w_state_n = ST_IDLE;
          w_q_n     = '0;
        end
      endcase
    end
  end

  assign q          = r_q;
  assign step       = r_step;
  assign cycle_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_led_seq_gen
// Brief    : Scoreboard bench for led_seq_gen (WIDTH=8), with or without
//            LED_SEQ_BOUNCE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_seq_gen;

  localparam int WIDTH = 8;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] q;
  logic             step;
  logic             cycle_done;

  always #5 clk = ~clk;

  led_seq_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .div        (div),
    .q          (q),
    .step       (step),
    .cycle_done (cycle_done)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       cd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] seq_lsb[16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] seq_msb[16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                              8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [7:0] seq_dot[9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
  logic [7:0] seq_bnc[15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h00};

  task automatic push_seq(input int m);
    case (m)
      0: for (int i = 0; i < 16; i++) sb.push_back('{q: seq_lsb[i], cd: (i == 15)});
      1: for (int i = 0; i < 16; i++) sb.push_back('{q: seq_msb[i], cd: (i == 15)});
      2: for (int i = 0; i < 9; i++)  sb.push_back('{q: seq_dot[i], cd: (i == 8)});
      default: begin
`ifdef LED_SEQ_BOUNCE_EN
        for (int i = 0; i < 15; i++) sb.push_back('{q: seq_bnc[i], cd: (i == 14)});
`else
        for (int i = 0; i < 16; i++) sb.push_back('{q: seq_lsb[i], cd: (i == 15)});
`endif
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_size(input int target, input int budget, input string name);
    int n = 0;
    while (sb.size() > target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check({name, "_timeout"}, 32'(sb.size() > target), 32'd0);
    if (sb.size() > target && target == 0) sb.delete();
  endtask

  task automatic wait_step(input int budget, output int gap);
    gap = 0;
    do begin
      @(negedge clk); gap++;
    end while (!step && gap < budget);
  endtask

  // Monitor: every step pulse must match the oldest expected update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (step) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step: q=%02h cd=%0b with empty scoreboard", q, cycle_done);
          end else begin
            e = sb.pop_front();
            if (q !== e.q || cycle_done !== e.cd) begin
              errors++;
              $display("FAIL step_value: got q=%02h cd=%0b expected q=%02h cd=%0b",
                       q, cycle_done, e.q, e.cd);
            end
          end
        end else if (cycle_done) begin
          checks++;
          errors++;
          $display("FAIL done_without_step: cycle_done=1 expected 0");
        end
      end
    end
  end

  initial begin
    int       gap;
    int       n;
    logic [7:0] hold;

    reset = 1'b1; enable = 1'b0; mode = 2'd0; div = '0;
    #2;
    check("reset_q", 32'(q), 32'h0);
    check("reset_step", 32'(step), 32'h0);
    check("reset_done", 32'(cycle_done), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fill-drain LSB, MSB, dot and mode 3 at div=0, back to back.
    mode = 2'd0; push_seq(0); enable = 1'b1;
    wait_size(0, 40, "mode0");
    mode = 2'd1; push_seq(1);
    wait_size(0, 40, "mode1");
    mode = 2'd2; push_seq(2);
    wait_size(0, 40, "mode2");
    mode = 2'd3; push_seq(3);
    wait_size(0, 40, "mode3");

    // Mode change mid-dot is ignored until the next IDLE tick.
    mode = 2'd2; push_seq(2); push_seq(0);
    wait_size(25 - 4, 20, "midchange");
    mode = 2'd0;
    wait_size(0, 60, "midchange_done");

    // div=4: 5-clock step period, then a 3-clock freeze mid-FILL.
    div = 24'd4; push_seq(0);
    wait_step(20, gap);
    wait_step(20, gap);
    check("div4_period", 32'(gap), 32'd5);
    hold = q;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n >= 3 && n <= 5) begin
        check("freeze_q", 32'(q), 32'(hold));
        check("freeze_step", 32'(step), 32'd0);
      end
      if (n == 2) enable = 1'b0;
      if (n == 5) enable = 1'b1;
    end while (!step && n < 20);
    check("freeze_resume_gap", 32'(n), 32'd8);
    wait_size(0, 120, "div4_done");

    // Asynchronous reset mid-DRAIN, then a fresh pattern from the start.
    div = 24'd3; push_seq(0);
    wait_size(6, 80, "pre_reset");
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_reset_q", 32'(q), 32'h0);
    check("async_reset_step", 32'(step), 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_seq(0);
    wait_size(0, 100, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_seq_gen.md
LED_SEQ_GEN -- requirements
Module: led_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LED count (legal 2..32).
REQ-002 SHALL have parameter DIV_W, default 24, prescaler counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run/freeze control.
REQ-006 SHALL have port mode  input  2  pattern select (0 fill-drain LSB side, 1 fill-drain MSB side, 2 running dot, 3 bounce).
REQ-007 SHALL have port div  input  DIV_W  step period minus one, in enabled clocks.
REQ-008 SHALL have port q  output  WIDTH  LED drive, registered.
REQ-009 SHALL have port step  output  1  one-cycle pulse coincident with each q update.
REQ-010 SHALL have port cycle_done  output  1  one-cycle pulse on the tick that returns q to zero.

Function
REQ-011 Prescaler SHALL count only while enable=1; tick when count>=div, count then clears to 0; div=0 gives a tick every enabled cycle.
REQ-012 enable=0 SHALL freeze count, state, q; step and cycle_done SHALL be 0.
REQ-013 A div change SHALL take effect immediately; count>=new div SHALL tick on the next enabled cycle.
REQ-014 q, step, cycle_done SHALL update on the edge where tick is true; latency tick-to-q is zero extra cycles.
REQ-015 FSM states: IDLE (q=0), FILL, DRAIN, RUN, BACK.
REQ-016 IDLE, on tick: latch mode; mode 0 -> FILL q=bit0; mode 1 -> FILL q=bit(WIDTH-1); mode 2/3 -> RUN q=bit0.
REQ-017 FILL mode 0: q=(q<<1)|1 per tick; mode 1: q=(q>>1)|MSB; when q all-ones, next tick -> DRAIN.
REQ-018 DRAIN mode 0: q=q<<1 (FF->FE); mode 1: q=q>>1 (FF->7F); tick producing q=0 -> IDLE, cycle_done=1.
REQ-019 RUN: q=q<<1; from MSB, mode 2 -> IDLE q=0 with cycle_done, mode 3 -> BACK q=bit(WIDTH-2).
REQ-020 BACK: q=q>>1; from bit1 -> IDLE q=0 with cycle_done.
REQ-021 Periods in ticks: modes 0/1 2*WIDTH, mode 2 WIDTH+1, mode 3 2*WIDTH-1.
REQ-022 mode changes mid-pattern SHALL be ignored until the next IDLE tick.
REQ-023 q SHALL never hold a value outside the active pattern sequence.

Reset
REQ-024 reset=1 SHALL immediately, without clock, force state IDLE, count 0, latched mode 0, q=0, step=0, cycle_done=0.
REQ-025 After reset release, the first tick SHALL produce the first pattern step; any mid-pattern progress is discarded.

Configuration
REQ-026 Macro LED_SEQ_BOUNCE_EN defined: mode 3 SHALL run bounce per REQ-019/020.
REQ-027 Macro undefined: BACK state SHALL not be built and mode 3 SHALL behave exactly as mode 0.

Structure
REQ-028 Shared package led_seq_pkg SHALL hold the state encodings and mode constants (MODE_FILL_LSB, MODE_FILL_MSB, MODE_DOT, MODE_BOUNCE).
REQ-029 Prescaler SHALL be sub-module led_seq_prescaler (inputs clk, reset, enable, div; output tick).

Verification (WIDTH=8)
REQ-030 mode=0, div=0, enable=1 -> q 01,03,07,..,FF,FE,FC,..,80,00; cycle_done only on tick 16.
REQ-031 div=4 -> step every 5 clocks; enable low 3 clocks mid-FILL -> q and count frozen, resumes same phase.
REQ-032 mode=1 -> q 80,C0,..,FF,7F,3F,..,01,00; mode=2 -> 01,02,..,80,00, cycle_done on tick 9.
REQ-033 mode 2->0 at tick 4 -> dot pattern completes, fill-drain starts after cycle_done.
REQ-034 reset asserted mid-DRAIN between edges -> q=00, step=0 before next clock.
REQ-035 mode=3: with LED_SEQ_BOUNCE_EN -> 01..80,40..02,00 (15 ticks); without -> identical to mode 0.
